// File: rtl/output_port_allocator.sv
// Wormhole switch allocator for one router output port: round-robin on head flits,
// output locked to the winning input until its tail flit leaves, gated by downstream credits.
module output_port_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int CREDITS   = 4,
    localparam int CW = $clog2(CREDITS + 1),
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] head,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 credit_in,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 out_valid,
    output logic                 locked,
    output logic [NUM_PORTS-1:0] owner,
    output logic [CW-1:0]        credits,
    output logic                 err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [NUM_PORTS-1:0] owner_q;
    logic [CW-1:0]        credit_q;
    logic                 err_q;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant_c;
    logic [PW-1:0]        win_idx;
    logic                 win_found;
    logic                 has_credit;
    logic                 send;
    logic                 send_tail;
    int                   j;

    // Circular scan for the first head-flit requester starting at the round-robin pointer.
    always_comb begin
        eligible  = req & head;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!win_found && eligible[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        has_credit = (credit_q != '0);
        grant_c    = '0;
        if (!rst && has_credit) begin
            if (state == IDLE) begin
                if (win_found) begin
                    grant_c[win_idx] = 1'b1;
                end
            end else begin
                grant_c = owner_q & req;
            end
        end
        send      = |grant_c;
        send_tail = |(grant_c & tail);
    end

    // A credit return with nothing sent while already full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner_q  <= '0;
            credit_q <= CW'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10: credit_q <= credit_q - CW'(1);
                2'b01: begin
                    if (credit_q == CW'(CREDITS)) begin
                        err_q <= 1'b1;
                    end else begin
                        credit_q <= credit_q + CW'(1);
                    end
                end
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    if (send) begin
                        ptr <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);
                        if (!send_tail) begin
                            state   <= LOCKED;
                            owner_q <= grant_c;
                        end
                    end
                end
                LOCKED: begin
                    if (|(owner_q & req & head)) begin
                        err_q <= 1'b1;
                    end
                    if (send_tail) begin
                        state   <= IDLE;
                        owner_q <= '0;
                    end
                end
            endcase
        end
    end

    assign grant     = grant_c;
    assign out_valid = send;
    assign locked    = (state == LOCKED);
    assign owner     = owner_q;
    assign credits   = credit_q;
    assign err       = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: a packet-level reference model checked every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_output_port_allocator;

    localparam int N   = 5;
    localparam int CRD = 4;
    localparam int CW  = $clog2(CRD + 1);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  head;
    logic [N-1:0]  tail;
    logic          credit_in;
    logic [N-1:0]  grant;
    logic          out_valid;
    logic          locked;
    logic [N-1:0]  owner;
    logic [CW-1:0] credits;
    logic          err;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_valid  = 0;
    bit m_locked = 0;
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_credits = CRD;
    bit m_err    = 0;

    output_port_allocator #(.NUM_PORTS(N), .CREDITS(CRD)) dut (
        .clk(clk), .rst(rst), .req(req), .head(head), .tail(tail),
        .credit_in(credit_in), .grant(grant), .out_valid(out_valid),
        .locked(locked), .owner(owner), .credits(credits), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N-1:0] hd,
                                 input logic [N-1:0] tl, input logic ci);
        @(posedge clk);
        #1;
        rst = r; req = rq; head = hd; tail = tl; credit_in = ci;
        #1;
    endtask

    // Which input the rules say must cross the switch this cycle, -1 for none.
    function automatic int exp_idx();
        int p;
        if (rst || m_credits == 0) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (req[p] && head[p]) return p;
        end
        return -1;
    endfunction

    // Compare at the falling edge, advance the model at the rising edge.
    initial begin
        int g;
        logic [N-1:0] eg, eo;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                g  = exp_idx();
                eg = (g >= 0) ? N'(1) << g : '0;
                eo = m_locked ? N'(1) << m_owner : '0;
                checkOutput("model_grant", 32'(grant), 32'(eg));
                checkOutput("model_out_valid", 32'(out_valid), 32'(g >= 0));
                checkOutput("model_locked", 32'(locked), 32'(m_locked));
                checkOutput("model_owner", 32'(owner), 32'(eo));
                checkOutput("model_credits", 32'(credits), 32'(m_credits));
                checkOutput("model_err", 32'(err), 32'(m_err));
            end
            @(posedge clk);
            if (rst) begin
                m_valid = 1; m_locked = 0; m_owner = -1; m_ptr = 0; m_credits = CRD; m_err = 0;
            end else if (m_valid) begin
                g = exp_idx();
                if (m_locked && req[m_owner] && head[m_owner]) m_err = 1;
                if (g >= 0) begin
                    if (!m_locked) begin
                        m_ptr = (g + 1) % N;
                        if (!tail[g]) begin
                            m_locked = 1;
                            m_owner  = g;
                        end
                    end else if (tail[g]) begin
                        m_locked = 0;
                        m_owner  = -1;
                    end
                end
                if (credit_in && g < 0 && m_credits == CRD) m_err = 1;
                else m_credits = m_credits - ((g >= 0) ? 1 : 0) + (credit_in ? 1 : 0);
            end
        end
    end

    initial begin
        logic [N-1:0] rr_exp [6];
        rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        rst = 1'b1; req = '0; head = '0; tail = '0; credit_in = 1'b0;

        // single-flit packet and credit return
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 5'b00001, 5'b00001, 5'b00001, 0);
        checkOutput("reset_credits", 32'(credits), 4);
        checkOutput("reset_locked", 32'(locked), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_owner", 32'(owner), 0);
        checkOutput("single_grant", 32'(grant), 32'b00001);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single_credits_after", 32'(credits), 3);
        checkOutput("single_locked", 32'(locked), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("single_credit_return", 32'(credits), 4);

        // round-robin over five single-flit requesters
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 5'b11111, 5'b11111, 5'b11111, (i != 0));
            checkOutput($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_exp[i]));
            if (i != 0) checkOutput($sformatf("rr_credits_%0d", i), 32'(credits), 3);
        end

        // wormhole lock: input 2 holds the output against input 3
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 5'b01100, 5'b01100, 5'b01000, 1);
        checkOutput("wh_grant_head", 32'(grant), 32'b00100);
        applyStimulus(0, 5'b01100, 5'b01000, 5'b01000, 1);
        checkOutput("wh_grant_body", 32'(grant), 32'b00100);
        checkOutput("wh_owner_body", 32'(owner), 32'b00100);
        applyStimulus(0, 5'b01100, 5'b01000, 5'b01100, 1);
        checkOutput("wh_grant_tail", 32'(grant), 32'b00100);
        checkOutput("wh_locked_tail", 32'(locked), 1);
        applyStimulus(0, 5'b01000, 5'b01000, 5'b01000, 1);
        checkOutput("wh_grant_next", 32'(grant), 32'b01000);
        checkOutput("wh_unlocked", 32'(locked), 0);

        // credit stall on a 6-flit packet from input 1
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 5'b00010, 5'b00010, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 5'b00010, 0, 0, 0);
        checkOutput("stall_4th_grant", 32'(grant), 32'b00010);
        checkOutput("stall_credits_1", 32'(credits), 1);
        applyStimulus(0, 5'b00010, 0, 0, 0);
        checkOutput("stall_grant_zero", 32'(grant), 0);
        checkOutput("stall_credits_0", 32'(credits), 0);
        checkOutput("stall_locked", 32'(locked), 1);
        applyStimulus(0, 5'b00010, 0, 0, 1);
        checkOutput("stall_grant_on_ret", 32'(grant), 0);
        applyStimulus(0, 5'b00010, 0, 0, 0);
        checkOutput("stall_one_more", 32'(grant), 32'b00010);
        applyStimulus(0, 5'b00010, 0, 0, 0);
        checkOutput("stall_again", 32'(grant), 0);
        applyStimulus(0, 5'b00010, 0, 0, 1);
        applyStimulus(0, 5'b00010, 0, 5'b00010, 0);
        checkOutput("stall_tail_grant", 32'(grant), 32'b00010);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stall_released", 32'(locked), 0);

        // head flit from the owner while locked, then credit overflow
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 5'b00001, 5'b00001, 0, 1);
        applyStimulus(0, 5'b00001, 5'b00001, 0, 1);
        checkOutput("err_dup_head_grant", 32'(grant), 32'b00001);
        checkOutput("err_before", 32'(err), 0);
        applyStimulus(0, 5'b00001, 0, 5'b00001, 1);
        checkOutput("err_dup_head", 32'(err), 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ovf_err_cleared", 32'(err), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovf_credits", 32'(credits), 4);
        checkOutput("ovf_err", 32'(err), 1);

        // reset in the middle of a packet
        applyStimulus(0, 5'b01000, 5'b01000, 0, 0);
        checkOutput("mid_head_grant", 32'(grant), 32'b01000);
        applyStimulus(1, 5'b01000, 0, 0, 0);
        checkOutput("mid_rst_grant", 32'(grant), 0);
        checkOutput("mid_rst_locked_q", 32'(locked), 1);
        applyStimulus(0, 5'b10000, 5'b10000, 5'b10000, 0);
        checkOutput("mid_locked", 32'(locked), 0);
        checkOutput("mid_credits", 32'(credits), 4);
        checkOutput("mid_err", 32'(err), 0);
        checkOutput("mid_new_grant", 32'(grant), 32'b10000);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid_credits_after", 32'(credits), 3);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Per-output-port wormhole switch allocator for the mesh router. It arbitrates among the five input ports (North, South, West, East, Local) whose head flits carry this output in their one-hot lookahead routing field. Arbitration is round-robin on head flits, and the output is locked to the winner until its tail flit leaves. Downstream buffer credits gate every transfer. One instance sits beside each output port's crossbar mux; `grant` drives both the mux select and the input-FIFO dequeue.

## Interface
- `NUM_PORTS`, default 5: number of requesting input ports. Index order is North=0, South=1, West=2, East=3, Local=4, matching `noc::kNorthPort`..`noc::kLocalPort`.
- `CREDITS`, default 4: downstream input-buffer depth, i.e. the maximum number of flits in flight.
- Derived `CW = $clog2(CREDITS+1)`: width of the credit counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_PORTS  input i has a valid flit at its FIFO head whose routing selects this output.
- `head`  in  NUM_PORTS  input i's head-of-FIFO flit is a header flit. Qualified by `req[i]`.
- `tail`  in  NUM_PORTS  input i's head-of-FIFO flit is a tail flit. Qualified by `req[i]`. A single-flit packet has both `head` and `tail` set.
- `credit_in`  in  1  one downstream buffer slot freed this cycle.
- `grant`  out  NUM_PORTS  one-hot or zero; the flit of input i crosses the switch this cycle.
- `out_valid`  out  1  equals `|grant`.
- `locked`  out  1  the output is reserved by a packet in progress.
- `owner`  out  NUM_PORTS  one-hot lock holder; zero when not locked.
- `credits`  out  CW  current credit count.
- `err`  out  1  sticky protocol error.

## Operation
- State: `IDLE` or `LOCKED`, plus `owner`, round-robin pointer `ptr` (0..NUM_PORTS-1), `credits`, and `err`.
- `grant` is combinational from registered state and the current `req`/`head`/`tail`. It is 0 whenever `rst`=1 or `credits`=0.
- IDLE:
  - Eligible set is `req & head`.
  - Grant the first eligible index, scanning circularly from `ptr` upward.
  - On any grant, `ptr` becomes (granted index + 1) mod NUM_PORTS.
  - If the granted flit has `tail`=1, stay IDLE. Otherwise go to LOCKED with `owner` set to the granted index.
  - Non-head requests are ignored in IDLE and do not set `err`.
- LOCKED:
  - Only `owner` may be granted: `grant[owner] = req[owner] & (credits>0)`. Other requests wait and `ptr` is frozen.
  - A granted flit with `tail`=1 returns the state to IDLE and clears `owner` at the next edge. The next packet can win in the cycle after the tail.
  - `req[owner]` with `head`=1 while LOCKED sets `err`. That flit is still granted and treated as body/tail.
- Credits:
  - Next value is `credits - out_valid + credit_in`. A simultaneous send and return leaves the count unchanged.
  - A `credit_in` that would exceed CREDITS (with no send that cycle) is dropped and sets `err`.
  - The counter never underflows, because `grant` is gated by `credits>0`.
- `err` clears only on reset.

## Timing
- Reset values: state IDLE, `ptr`=0, `credits`=CREDITS, `owner`=0, `locked`=0, `err`=0, `grant`=0, `out_valid`=0.
- Request to grant: 0 cycles, same cycle, when credits>0 and arbitration is won.
- `credit_in` takes effect the following cycle. With `credits`=0 and `credit_in`=1 in cycle t, the earliest grant is cycle t+1.
- Lock acquisition and release are visible on `locked`/`owner` one cycle after the granting edge.
- Throughput: one flit per cycle while credits last. A packet of L flits holds the output for at least L cycles.
- Reset asserted mid-packet: everything returns to reset values at the next edge. `grant` is forced 0 during the reset cycle. Upstream and downstream are reset together.

## Test plan
- Reset, then single-flit packet: `req`=5'b00001, `head`=`tail`=5'b00001 -> `grant`=5'b00001 in the same cycle. `credits` goes 4→3, `locked` stays 0, `ptr`=1. Then `credit_in`=1 -> `credits`=4.
- Round-robin fairness: all five inputs continuously present single-flit packets, `credit_in`=1 every cycle -> grants rotate 0,1,2,3,4,0 with one grant per cycle. `credits` holds at 3 after the first cycle.
- Wormhole lock: input 2 sends head, body, tail over 3 cycles while input 3 requests with a head flit throughout -> grants are 2,2,2 then 3. `locked`=1 and `owner`=5'b00100 during the body/tail cycles.
- Credit stall: CREDITS=4 and a 6-flit packet from input 1 with no `credit_in` -> 4 grants, then `grant`=0 with `locked` held. One `credit_in` pulse -> exactly one more grant in the next cycle.
- Errors: a head flit from the owner while LOCKED -> `err`=1. Separately, after reset, `credit_in`=1 with `credits`=4 -> `credits` stays 4 and `err`=1.
- Reset mid-packet: assert `rst` after the head of a 4-flit packet -> the next cycle shows `locked`=0, `credits`=4, `err`=0, `grant`=0 during reset. A new head on input 4 is granted immediately after reset deasserts.
